// File: rtl/net_seq_ctrl_pkg.sv
// Shared constants, state encodings and bus types for the 7-15-2 net sequencer.
// Optional checksum feature is selected with the CFG_CHECKSUM_EN macro.
package net_seq_ctrl_pkg;

   localparam int DATA_W    = 32;
   localparam int N_IN      = 7;
   localparam int N_HID     = 15;
   localparam int N_OUT     = 2;
   localparam int N_NEUR    = N_HID + N_OUT;
   localparam int ADDR_W    = 5;
   localparam int NEUR_W    = $clog2(N_NEUR);
   localparam int TO_CYC    = 1024;
   localparam int CYC_W     = $clog2(TO_CYC);

   localparam int HID_DEPTH   = N_IN + 1;
   localparam int OUT_DEPTH   = N_HID + 1;
   localparam int TOTAL_WORDS = N_HID * HID_DEPTH + N_OUT * OUT_DEPTH;

   localparam logic [ADDR_W-1:0] HID_BIAS_ADDR = ADDR_W'(N_IN);
   localparam logic [ADDR_W-1:0] OUT_BIAS_ADDR = ADDR_W'(N_HID);

   typedef logic [DATA_W-1:0] word_data_bus_t;

   localparam logic [1:0] S_LOAD = 2'd0;
   localparam logic [1:0] S_CHK  = 2'd1;
   localparam logic [1:0] S_IDLE = 2'd2;
   localparam logic [1:0] S_RUN  = 2'd3;

   // Hidden neurons occupy the low strobe bits, output neurons follow.
   function automatic logic [N_NEUR-1:0] neuron_onehot(input logic [NEUR_W-1:0] n);
      return {{(N_NEUR-1){1'b0}}, 1'b1} << n;
   endfunction

endpackage

// File: rtl/net_seq_ctrl_if.sv
// Weight stream from the host plus the shared WRAM write bus towards the net.
// master = sequencer side, slave = host/net side.
interface net_seq_ctrl_if;
   import net_seq_ctrl_pkg::*;

   logic                cfg_valid;
   logic                cfg_ready;
   word_data_bus_t      cfg_data;
   logic                cfg_reload;

   logic [N_NEUR-1:0]   wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   word_data_bus_t      wr_data;

   modport master (
      input  cfg_valid, cfg_data, cfg_reload,
      output cfg_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      output cfg_valid, cfg_data, cfg_reload,
      input  cfg_ready, wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/net_seq_ctrl_wram_addr_gen.sv
// Neuron/address counter pair walking every WRAM word in load order.
// Hidden neurons are N_IN+1 deep, output neurons N_HID+1 deep.
module wram_addr_gen
   import net_seq_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              advance,
   output logic [NEUR_W-1:0] neuron,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   logic [NEUR_W-1:0] neuron_q, neuron_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] bias_addr;

   // The bias word closes each neuron; the last output bias wraps back to word 0.
   always_comb begin
      bias_addr = (neuron_q < NEUR_W'(N_HID)) ? HID_BIAS_ADDR : OUT_BIAS_ADDR;
      last      = (neuron_q == NEUR_W'(N_NEUR - 1)) && (addr_q == OUT_BIAS_ADDR);
      neuron_d  = neuron_q;
      addr_d    = addr_q;
      if (clear) begin
         neuron_d = '0;
         addr_d   = '0;
      end else if (advance) begin
         if (last) begin
            neuron_d = '0;
            addr_d   = '0;
         end else if (addr_q == bias_addr) begin
            neuron_d = neuron_q + 1'b1;
            addr_d   = '0;
         end else begin
            addr_d = addr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         neuron_q <= '0;
         addr_q   <= '0;
      end else begin
         neuron_q <= neuron_d;
         addr_q   <= addr_d;
      end
   end

   assign neuron = neuron_q;
   assign addr   = addr_q;

endmodule

// File: rtl/net_seq_ctrl.sv
// Sequencer for the 7-15-2 net: loads every neuron's WRAM, then runs inferences.
// Define CFG_CHECKSUM_EN to add a trailing checksum word and the chk_err output.
module net_seq_ctrl
   import net_seq_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   net_seq_ctrl_if.master bus,
   input  logic           start,
   output logic           net_in_rdy,
   input  logic           net_rdy,
   input  word_data_bus_t net_out_0,
   input  word_data_bus_t net_out_1,
   output word_data_bus_t res_0,
   output word_data_bus_t res_1,
   output logic           res_valid,
   output logic           load_done,
   output logic           busy,
   output logic           to_err
`ifdef CFG_CHECKSUM_EN
   ,
   output logic           chk_err
`endif
);

   logic [1:0]        state_q, state_d;
   logic [N_NEUR-1:0] wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   word_data_bus_t    wr_data_q, wr_data_d;
   logic              load_done_q, load_done_d;
   logic              in_rdy_q, in_rdy_d;
   word_data_bus_t    res_0_q, res_0_d;
   word_data_bus_t    res_1_q, res_1_d;
   logic              res_valid_q, res_valid_d;
   logic              to_err_q, to_err_d;
   logic [CYC_W-1:0]  cyc_q, cyc_d;
`ifdef CFG_CHECKSUM_EN
   word_data_bus_t    sum_q, sum_d;
   logic              chk_err_q, chk_err_d;
`endif

   logic              accept;
   logic              gen_clear;
   logic              gen_advance;
   logic [NEUR_W-1:0] gen_neuron;
   logic [ADDR_W-1:0] gen_addr;
   logic              gen_last;

   wram_addr_gen u_addr_gen (
      .clk     (clk),
      .reset   (reset),
      .clear   (gen_clear),
      .advance (gen_advance),
      .neuron  (gen_neuron),
      .addr    (gen_addr),
      .last    (gen_last)
   );

   assign bus.cfg_ready = (state_q == S_LOAD) || (state_q == S_CHK);
   assign accept        = bus.cfg_valid && bus.cfg_ready;

   always_comb begin
      state_d     = state_q;
      wr_en_d     = '0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      load_done_d = load_done_q;
      in_rdy_d    = in_rdy_q;
      res_0_d     = res_0_q;
      res_1_d     = res_1_q;
      res_valid_d = 1'b0;
      to_err_d    = to_err_q;
      cyc_d       = cyc_q;
      gen_clear   = 1'b0;
      gen_advance = 1'b0;
`ifdef CFG_CHECKSUM_EN
      sum_d       = sum_q;
      chk_err_d   = chk_err_q;
`endif
      case (state_q)
         S_LOAD: begin
            if (accept) begin
               wr_en_d     = neuron_onehot(gen_neuron);
               wr_addr_d   = gen_addr;
               wr_data_d   = bus.cfg_data;
               gen_advance = 1'b1;
`ifdef CFG_CHECKSUM_EN
               sum_d       = sum_q + bus.cfg_data;
               if (gen_last) begin
                  state_d = S_CHK;
               end
`else
               if (gen_last) begin
                  state_d     = S_IDLE;
                  load_done_d = 1'b1;
               end
`endif
            end
         end
         S_CHK: begin
`ifdef CFG_CHECKSUM_EN
            // The address generator has already wrapped, so a mismatch reloads from word 0.
            if (accept) begin
               if (bus.cfg_data == sum_q) begin
                  state_d     = S_IDLE;
                  load_done_d = 1'b1;
               end else begin
                  state_d   = S_LOAD;
                  chk_err_d = 1'b1;
                  sum_d     = '0;
               end
            end
`else
            state_d = S_LOAD;
`endif
         end
         S_IDLE: begin
            if (bus.cfg_reload) begin
               state_d     = S_LOAD;
               load_done_d = 1'b0;
               gen_clear   = 1'b1;
`ifdef CFG_CHECKSUM_EN
               sum_d       = '0;
               chk_err_d   = 1'b0;
`endif
            end else if (start) begin
               state_d  = S_RUN;
               in_rdy_d = 1'b1;
               to_err_d = 1'b0;
               cyc_d    = '0;
            end
         end
         S_RUN: begin
            // in_rdy stays high for at most TO_CYC cycles before giving up.
            if (net_rdy) begin
               res_0_d     = net_out_0;
               res_1_d     = net_out_1;
               res_valid_d = 1'b1;
               in_rdy_d    = 1'b0;
               state_d     = S_IDLE;
            end else if (cyc_q == CYC_W'(TO_CYC - 1)) begin
               to_err_d = 1'b1;
               in_rdy_d = 1'b0;
               state_d  = S_IDLE;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_LOAD;
         wr_en_q     <= '0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         load_done_q <= 1'b0;
         in_rdy_q    <= 1'b0;
         res_0_q     <= '0;
         res_1_q     <= '0;
         res_valid_q <= 1'b0;
         to_err_q    <= 1'b0;
         cyc_q       <= '0;
`ifdef CFG_CHECKSUM_EN
         sum_q       <= '0;
         chk_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         load_done_q <= load_done_d;
         in_rdy_q    <= in_rdy_d;
         res_0_q     <= res_0_d;
         res_1_q     <= res_1_d;
         res_valid_q <= res_valid_d;
         to_err_q    <= to_err_d;
         cyc_q       <= cyc_d;
`ifdef CFG_CHECKSUM_EN
         sum_q       <= sum_d;
         chk_err_q   <= chk_err_d;
`endif
      end
   end

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign net_in_rdy  = in_rdy_q;
   assign res_0       = res_0_q;
   assign res_1       = res_1_q;
   assign res_valid   = res_valid_q;
   assign load_done   = load_done_q;
   assign busy        = (state_q != S_IDLE);
   assign to_err      = to_err_q;
`ifdef CFG_CHECKSUM_EN
   assign chk_err     = chk_err_q;
`endif

   wr_en_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(wr_en_q));
   in_rdy_only_in_run: assert property (@(posedge clk) disable iff (reset)
      in_rdy_q |-> (state_q == S_RUN));

endmodule

// File: tb/tb_net_seq_ctrl.sv
// Self-checking bench for net_seq_ctrl: spec-level model compared every cycle plus literal checks.
// Build with CFG_CHECKSUM_EN to exercise the checksum word and chk_err.
module tb_net_seq_ctrl;
   import net_seq_ctrl_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           reset;
   logic           start;
   logic           net_in_rdy;
   logic           net_rdy = 1'b0;
   word_data_bus_t net_out_0, net_out_1;
   word_data_bus_t res_0, res_1;
   logic           res_valid, load_done, busy, to_err;
`ifdef CFG_CHECKSUM_EN
   logic           chk_err;
`endif

   net_seq_ctrl_if bus ();

   net_seq_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .start      (start),
      .net_in_rdy (net_in_rdy),
      .net_rdy    (net_rdy),
      .net_out_0  (net_out_0),
      .net_out_1  (net_out_1),
      .res_0      (res_0),
      .res_1      (res_1),
      .res_valid  (res_valid),
      .load_done  (load_done),
      .busy       (busy),
      .to_err     (to_err)
`ifdef CFG_CHECKSUM_EN
      ,
      .chk_err    (chk_err)
`endif
   );

   int checks   = 0;
   int failures = 0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   localparam int M_LOAD = 0;
   localparam int M_IDLE = 1;
   localparam int M_RUN  = 2;
   localparam int M_CHK  = 3;

   int                m_mode = M_LOAD;
   int                m_k    = 0;
   int                m_run  = 0;
   word_data_bus_t    m_sum  = '0;
   bit                model_valid = 1'b0;
   logic [N_NEUR-1:0] exp_wr_en = '0;
   logic [ADDR_W-1:0] exp_wr_addr = '0;
   word_data_bus_t    exp_wr_data = '0;
   logic              exp_load_done = 1'b0, exp_in_rdy = 1'b0, exp_res_valid = 1'b0;
   logic              exp_to_err = 1'b0, exp_chk_err = 1'b0;
   word_data_bus_t    exp_res0 = '0, exp_res1 = '0;

   task automatic locate(input int k, output int n, output int a);
      int j;
      if (k < N_HID * (N_IN + 1)) begin
         n = k / (N_IN + 1);
         a = k % (N_IN + 1);
      end else begin
         j = k - N_HID * (N_IN + 1);
         n = N_HID + j / (N_HID + 1);
         a = j % (N_HID + 1);
      end
   endtask

   always @(posedge clk) begin
      int n, a;
      exp_wr_en     = '0;
      exp_res_valid = 1'b0;
      if (reset) begin
         m_mode = M_LOAD; m_k = 0; m_run = 0; m_sum = '0;
         exp_load_done = 1'b0; exp_in_rdy = 1'b0; exp_to_err = 1'b0; exp_chk_err = 1'b0;
         exp_res0 = '0; exp_res1 = '0;
         model_valid = 1'b1;
      end else begin
         case (m_mode)
            M_LOAD: if (bus.cfg_valid) begin
               locate(m_k, n, a);
               exp_wr_en[n] = 1'b1;
               exp_wr_addr  = ADDR_W'(a);
               exp_wr_data  = bus.cfg_data;
               m_sum        = m_sum + bus.cfg_data;
               m_k++;
               if (m_k == TOTAL_WORDS) begin
                  m_k = 0;
`ifdef CFG_CHECKSUM_EN
                  m_mode = M_CHK;
`else
                  m_mode = M_IDLE;
                  exp_load_done = 1'b1;
`endif
               end
            end
            M_CHK: if (bus.cfg_valid) begin
               if (bus.cfg_data == m_sum) begin
                  exp_load_done = 1'b1;
                  m_mode = M_IDLE;
               end else begin
                  exp_chk_err = 1'b1;
                  m_mode = M_LOAD;
               end
               m_sum = '0;
            end
            M_IDLE: begin
               if (bus.cfg_reload) begin
                  m_mode = M_LOAD; m_k = 0; m_sum = '0;
                  exp_load_done = 1'b0; exp_chk_err = 1'b0;
               end else if (start) begin
                  m_mode = M_RUN; m_run = 0;
                  exp_in_rdy = 1'b1; exp_to_err = 1'b0;
               end
            end
            M_RUN: begin
               if (net_rdy) begin
                  exp_res0 = net_out_0; exp_res1 = net_out_1;
                  exp_res_valid = 1'b1; exp_in_rdy = 1'b0;
                  m_mode = M_IDLE;
               end else begin
                  m_run++;
                  if (m_run == TO_CYC) begin
                     exp_to_err = 1'b1; exp_in_rdy = 1'b0;
                     m_mode = M_IDLE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      if (model_valid) begin
         checkOutput("cfg_ready", bus.cfg_ready, (m_mode == M_LOAD) || (m_mode == M_CHK));
         checkOutput("busy", busy, m_mode != M_IDLE);
         checkOutput("wr_en", bus.wr_en, exp_wr_en);
         if (exp_wr_en != '0) begin
            checkOutput("wr_addr", bus.wr_addr, exp_wr_addr);
            checkOutput("wr_data", bus.wr_data, exp_wr_data);
         end
         checkOutput("load_done", load_done, exp_load_done);
         checkOutput("net_in_rdy", net_in_rdy, exp_in_rdy);
         checkOutput("res_valid", res_valid, exp_res_valid);
         checkOutput("res_0", res_0, exp_res0);
         checkOutput("res_1", res_1, exp_res1);
         checkOutput("to_err", to_err, exp_to_err);
`ifdef CFG_CHECKSUM_EN
         checkOutput("chk_err", chk_err, exp_chk_err);
`endif
      end
   end

   // ---------------- WRAM capture and net model ----------------
   word_data_bus_t wram [N_NEUR][N_HID+1];
   int wr_count = 0;
   int rv_count = 0;

   always begin
      @(posedge clk);
      #1;
      if (bus.wr_en != '0) begin
         for (int n = 0; n < N_NEUR; n++)
            if (bus.wr_en[n] && bus.wr_addr <= ADDR_W'(N_HID)) wram[n][bus.wr_addr] = bus.wr_data;
         wr_count++;
      end
      if (res_valid === 1'b1) rv_count++;
   end

   int   net_delay = 0;
   logic net_force = 1'b0;
   int   in_cnt    = 0;
   int   hi_cycles = 0;

   always begin
      @(negedge clk);
      #1;
      if (net_in_rdy === 1'b1) begin
         in_cnt++;
         hi_cycles++;
      end else begin
         in_cnt = 0;
      end
      net_rdy = net_force || (net_delay != 0 && in_cnt == net_delay);
   end

   // ---------------- stimulus ----------------
   task automatic applyStimulus(input word_data_bus_t base, input int count, input int gap,
                                input int bad_chk, input bit check_done);
      word_data_bus_t s;
      s = '0;
      for (int k = 0; k < count; k++) begin
         repeat (gap) begin
            @(negedge clk);
            bus.cfg_valid = 1'b0;
         end
         @(negedge clk);
         bus.cfg_valid = 1'b1;
         bus.cfg_data  = base + word_data_bus_t'(k);
         s = s + bus.cfg_data;
      end
`ifdef CFG_CHECKSUM_EN
      if (count == TOTAL_WORDS) begin
         @(negedge clk);
         bus.cfg_valid = 1'b1;
         bus.cfg_data  = s + word_data_bus_t'(bad_chk);
      end
`endif
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      if (check_done) checkOutput("load_done_rise", load_done, bad_chk == 0);
   endtask

   task automatic startPulse();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic reloadPulse();
      @(negedge clk);
      bus.cfg_reload = 1'b1;
      @(negedge clk);
      bus.cfg_reload = 1'b0;
   endtask

   task automatic waitRes(input int max_cyc);
      bit got;
      got = 1'b0;
      for (int i = 0; i < max_cyc && !got; i++) begin
         @(negedge clk);
         got = (res_valid === 1'b1);
      end
      checkOutput("wait_res_valid", got, 1);
   endtask

   task automatic waitErr(input int max_cyc);
      bit got;
      got = 1'b0;
      for (int i = 0; i < max_cyc && !got; i++) begin
         @(negedge clk);
         got = (to_err === 1'b1);
      end
      checkOutput("wait_to_err", got, 1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      bus.cfg_valid = 1'b0; bus.cfg_data = '0; bus.cfg_reload = 1'b0;
      net_out_0 = '0; net_out_1 = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst_cfg_ready", bus.cfg_ready, 1);
      checkOutput("rst_busy", busy, 1);
      checkOutput("rst_wr_en", bus.wr_en, 0);
      checkOutput("rst_wr_addr", bus.wr_addr, 0);
      checkOutput("rst_wr_data", bus.wr_data, 0);
      checkOutput("rst_load_done", load_done, 0);
      checkOutput("rst_in_rdy", net_in_rdy, 0);
      checkOutput("rst_res_0", res_0, 0);
      checkOutput("rst_to_err", to_err, 0);
      reset = 1'b0;

      // Back-to-back load of words 0..151.
      wr_count = 0;
      applyStimulus(32'd0, TOTAL_WORDS, 0, 0, 1'b1);
      @(negedge clk);
      checkOutput("load1_count", wr_count, 152);
      checkOutput("load1_h0_a0", wram[0][0], 0);
      checkOutput("load1_h0_a7", wram[0][7], 7);
      checkOutput("load1_o0_a0", wram[15][0], 120);
      checkOutput("load1_o1_a15", wram[16][15], 151);
      checkOutput("load1_cfg_ready", bus.cfg_ready, 0);

      // Reload with cfg_valid one cycle in three.
      reloadPulse();
      checkOutput("reload_load_done", load_done, 0);
      wr_count = 0;
      applyStimulus(32'd1000, TOTAL_WORDS, 2, 0, 1'b1);
      @(negedge clk);
      checkOutput("load2_count", wr_count, 152);
      checkOutput("load2_h0_a0", wram[0][0], 1000);
      checkOutput("load2_h8_a3", wram[8][3], 1067);
      checkOutput("load2_o1_a15", wram[16][15], 1151);

      // net_rdy while idle is ignored.
      net_out_0 = 32'hDEAD; net_out_1 = 32'hBEEF;
      @(negedge clk); net_force = 1'b1;
      repeat (2) @(negedge clk);
      net_force = 1'b0;
      checkOutput("idle_net_rdy_res_0", res_0, 0);

      // Normal inference, net answers after 20 cycles.
      net_out_0 = 32'h1234; net_out_1 = 32'hABCD;
      net_delay = 20; hi_cycles = 0; rv_count = 0;
      startPulse();
      waitRes(100);
      checkOutput("run_in_rdy_cycles", hi_cycles, 20);
      checkOutput("run_res_0", res_0, 32'h1234);
      checkOutput("run_res_1", res_1, 32'hABCD);
      repeat (3) @(negedge clk);
      checkOutput("run_res_valid_count", rv_count, 1);

      // Net never answers: timeout.
      net_delay = 0; hi_cycles = 0; net_out_0 = 32'h5555; net_out_1 = 32'h6666;
      startPulse();
      waitErr(TO_CYC + 50);
      checkOutput("to_in_rdy_cycles", hi_cycles, TO_CYC);
      checkOutput("to_in_rdy", net_in_rdy, 0);
      checkOutput("to_busy", busy, 0);
      checkOutput("to_res_0_held", res_0, 32'h1234);
      checkOutput("to_no_res_valid", rv_count, 1);

      // Next start clears to_err.
      net_delay = 5;
      startPulse();
      checkOutput("restart_to_err", to_err, 0);
      checkOutput("restart_in_rdy", net_in_rdy, 1);
      waitRes(50);
      checkOutput("restart_res_0", res_0, 32'h5555);
      net_delay = 0;

      // Reset in the middle of a load, start ignored while loading.
      reloadPulse();
      applyStimulus(32'd2000, 60, 0, 0, 1'b0);
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      checkOutput("midrst_load_done", load_done, 0);
      checkOutput("midrst_cfg_ready", bus.cfg_ready, 1);
      startPulse();
      checkOutput("load_start_in_rdy", net_in_rdy, 0);
      checkOutput("load_start_busy", busy, 1);
      wr_count = 0;
      applyStimulus(32'd3000, TOTAL_WORDS, 0, 0, 1'b1);
      @(negedge clk);
      checkOutput("load3_count", wr_count, 152);
      checkOutput("load3_h0_a0", wram[0][0], 3000);
      checkOutput("load3_h7_a7", wram[7][7], 3063);
      checkOutput("load3_o1_a15", wram[16][15], 3151);

`ifdef CFG_CHECKSUM_EN
      // Wrong checksum bounces back to loading.
      reloadPulse();
      applyStimulus(32'd0, TOTAL_WORDS, 0, 1, 1'b1);
      checkOutput("bad_chk_err", chk_err, 1);
      checkOutput("bad_chk_cfg_ready", bus.cfg_ready, 1);
      applyStimulus(32'd0, TOTAL_WORDS, 0, 0, 1'b1);
`endif

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      failures++;
      $display("[TB] FAIL watchdog: simulation did not finish, failures=%0d", failures);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
